// File: rtl/mersenne_sched.sv
// mersenne_sched: shares one Mersenne-twister word generator among NREQ
// requesters. After reset the block waits SEED_CYCLES clocks for the
// generator to seed, then issues one word per grant using masked
// round-robin arbitration.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   req        per-requester level request (held until ack)
//   gen_rnd    generator output, valid the cycle after gen_ce
//   gen_ce     generator clock enable, high in the grant cycle
//   ready      high once seeding is complete
//   ack        one-hot pulse returning the word to the winner
//   rnd_out    delivered word, held while rnd_valid is low
//   rnd_valid  OR of ack
//
// Build option: define MERSENNE_SCHED_PRIO_EN to give requester 0 strict
// priority; the remaining requesters then share round-robin and grants to
// requester 0 do not move the round-robin pointer.
module mersenne_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned SEED_CYCLES = 624,
  parameter int unsigned CNT_W       = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [31:0]     gen_rnd,
  output logic            gen_ce,
  output logic            ready,
  output logic [NREQ-1:0] ack,
  output logic [31:0]     rnd_out,
  output logic            rnd_valid
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    SEED = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NREQ-1:0]   ack_q;
  logic [IDX_W-1:0]  last_q;
  logic [31:0]       hold_q;

  logic [NREQ-1:0]   elig_c;
  logic [NREQ-1:0]   rr_c;
  logic              grant_c;
  logic              upd_last_c;
  logic [IDX_W-1:0]  win_c;

  // Wrapped requester index base+k (mod NREQ).
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                               input int unsigned k);
    return IDX_W'((32'(base) + k) % NREQ);
  endfunction

  // Winner selection. The requester granted last cycle is the one acked
  // this cycle, so ack_q doubles as the previous-grant mask.
  always_comb begin
    elig_c     = '0;
    rr_c       = '0;
    grant_c    = 1'b0;
    upd_last_c = 1'b0;
    win_c      = '0;
    if (state_q == RUN) begin
      elig_c = req & ~ack_q;
    end
    rr_c = elig_c;
`ifdef MERSENNE_SCHED_PRIO_EN
    rr_c[0] = 1'b0;
`endif
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!grant_c && rr_c[rr_idx(last_q, k)]) begin
        grant_c    = 1'b1;
        upd_last_c = 1'b1;
        win_c      = rr_idx(last_q, k);
      end
    end
`ifdef MERSENNE_SCHED_PRIO_EN
    if (elig_c[0]) begin
      grant_c    = 1'b1;
      upd_last_c = 1'b0;
      win_c      = '0;
    end
`endif
  end

  // Seed FSM, grant registration and word hold register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
      cnt_q   <= '0;
      ack_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      hold_q  <= '0;
    end else begin
      case (state_q)
        SEED: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SEED_CYCLES - 1)) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= SEED;
        end
      endcase
      ack_q <= grant_c ? (NREQ'(1) << win_c) : '0;
      if (upd_last_c) begin
        last_q <= win_c;
      end
      if (|ack_q) begin
        hold_q <= gen_rnd;
      end
    end
  end

  // gen_rnd is the generator's own registered output, so the word passes
  // straight through in the ack cycle and is held afterwards.
  assign gen_ce    = grant_c;
  assign ready     = (state_q == RUN);
  assign ack       = ack_q;
  assign rnd_valid = |ack_q;
  assign rnd_out   = rnd_valid ? gen_rnd : hold_q;

endmodule

// File: tb/tb_mersenne_sched.sv
// Self-checking bench for mersenne_sched against a cycle-level reference
// model built from the arbitration rules (seed wait, previous-grant mask,
// round-robin pointer, optional requester-0 priority).
module tb_mersenne_sched;

  localparam int unsigned NREQ        = 4;
  localparam int unsigned SEED_CYCLES = 624;
  localparam int unsigned CNT_W       = 11;
`ifdef MERSENNE_SCHED_PRIO_EN
  localparam bit PRIO_M = 1'b1;
`else
  localparam bit PRIO_M = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [31:0]     gen_rnd = '0;
  logic            gen_ce;
  logic            ready;
  logic [NREQ-1:0] ack;
  logic [31:0]     rnd_out;
  logic            rnd_valid;

  logic [31:0]     next_word = 32'h1234_5678;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit              run_m;
  int              seed_m;
  int              last_m;
  int              prev_m;
  bit              exp_ce;
  logic [NREQ-1:0] exp_ack;
  logic [31:0]     exp_rnd;

  // requester behaviour
  logic [NREQ-1:0] act_mask;
  logic [NREQ-1:0] waiting;
  int              pct;
  int              wait_cnt [NREQ];

  mersenne_sched #(
    .NREQ        (NREQ),
    .SEED_CYCLES (SEED_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gen_rnd   (gen_rnd),
    .gen_ce    (gen_ce),
    .ready     (ready),
    .ack       (ack),
    .rnd_out   (rnd_out),
    .rnd_valid (rnd_valid)
  );

  always #5 clk = ~clk;

  // Generator stand-in: a fresh word appears the cycle after gen_ce.
  always @(posedge clk) begin
    if (gen_ce) begin
      gen_rnd   <= next_word;
      next_word <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    run_m   = 1'b0;
    seed_m  = 0;
    last_m  = NREQ - 1;
    prev_m  = -1;
    exp_ce  = 1'b0;
    exp_ack = '0;
    exp_rnd = '0;
  endtask

  task automatic check_regs();
    check("ready",     32'(ready),     32'(run_m));
    check("ack",       32'(ack),       32'(exp_ack));
    check("rnd_valid", 32'(rnd_valid), 32'(|exp_ack));
    check("rnd_out",   rnd_out,        exp_rnd);
  endtask

  // Requesters hold req until acked, keep it through the ack cycle, then
  // choose freely again.
  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ack[i]) begin
        req[i]     = 1'b1;
        waiting[i] = 1'b0;
`ifndef MERSENNE_SCHED_PRIO_EN
        check("starve", 32'(wait_cnt[i] <= 2 * NREQ), 32'd1);
`endif
      end else if (waiting[i]) begin
        req[i] = 1'b1;
        if (run_m) wait_cnt[i]++;
      end else begin
        req[i]      = act_mask[i] && (int'($urandom_range(0, 99)) < pct);
        waiting[i]  = req[i];
        wait_cnt[i] = 0;
      end
    end
  endtask

  // One cycle of the reference: decide this cycle's grant from req.
  task automatic model_cycle();
    int win;
    win = -1;
    if (run_m) begin
      if (PRIO_M && req[0] && prev_m != 0) win = 0;
      for (int k = 1; k <= NREQ && win < 0; k++) begin
        int idx;
        idx = (last_m + k) % NREQ;
        if (req[idx] && idx != prev_m && !(PRIO_M && idx == 0)) win = idx;
      end
    end
    exp_ce = (win >= 0);
    check("gen_ce", 32'(gen_ce), 32'(exp_ce));
    if (win >= 0) begin
      exp_ack = NREQ'(1) << win;
      exp_rnd = next_word;
    end else begin
      exp_ack = '0;
    end
    prev_m = win;
    if (win >= 0 && !(PRIO_M && win == 0)) last_m = win;
    if (!run_m) begin
      if (seed_m == SEED_CYCLES - 1) run_m = 1'b1;
      else seed_m++;
    end
  endtask

  task automatic step();
    drive_req();
    #1;
    model_cycle();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // Pull reset in a cycle where a grant is in flight.
  task automatic reset_mid();
    bit hit;
    hit = 1'b0;
    for (int g = 0; g < 50 && !hit; g++) begin
      drive_req();
      #1;
      model_cycle();
      if (exp_ce) begin
        rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_ready", 32'(ready),     32'd0);
        check("rst_ce",    32'(gen_ce),    32'd0);
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_rnd",   rnd_out,        32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        rst = 1'b1;
        hit = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        check_regs();
      end
    end
    check("rst_hit", 32'(hit), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    waiting  = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    act_mask = '1;
    pct      = 100;
    rst      = 1'b0;
    #2;
    drive_req();
    #1;
    check("init_ce", 32'(gen_ce), 32'd0);
    check_regs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // seed wait with all requesters pending, then round-robin 0,1,2,3
    repeat (SEED_CYCLES + 40) step();

    // single requester: every other cycle
    act_mask = 4'b0100;
    repeat (30) step();

    // 1011 held (priority build: 0 alternates with 1/3)
    act_mask = 4'b1011;
    repeat (30) step();

    // reset during an in-flight word, then full seed wait again
    act_mask = '1;
    repeat (5) step();
    reset_mid();
    act_mask = 4'($urandom);
    pct      = 50;
    repeat (SEED_CYCLES + 10) step();

    // random traffic
    for (int b = 0; b < 20; b++) begin
      act_mask = (b % 3 == 0) ? 4'($urandom) : '1;
      pct      = int'($urandom_range(5, 100));
      repeat (500) step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
